// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among CORES writeback requesters.
// Optional REGARB_ZERO_DROP_EN: address-0 requests are accepted but silently discarded.
module regfile_write_arbiter #(
  parameter int CORES  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int ID_W  = $clog2(CORES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CORES-1:0]         req_valid,
  output logic [CORES-1:0]         req_ready,
  input  logic [CORES*ADDR_W-1:0]  req_addr,
  input  logic [CORES*DATA_W-1:0]  req_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  logic [CORES-1:0]  pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q [CORES];
  logic [ADDR_W-1:0] pend_addr_d [CORES];
  logic [DATA_W-1:0] pend_data_q [CORES];
  logic [DATA_W-1:0] pend_data_d [CORES];
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  logic [CORES-1:0]  gnt;
  logic [CORES-1:0]  accept;
  logic [CORES-1:0]  fill;
  logic [ID_W-1:0]   gnt_idx;
  logic              any_gnt;
  logic [ID_W:0]     cand;

  // Rotating priority: scan from rr_ptr upward, wrapping, first pending entry wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    for (int k = 0; k < CORES; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(CORES)) begin
        cand = cand - (ID_W+1)'(CORES);
      end
      if (!any_gnt && pend_q[cand[ID_W-1:0]]) begin
        any_gnt = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
    if (any_gnt) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CORES; gi++) begin : g_core
      assign req_ready[gi] = !pend_q[gi] | gnt[gi];
      assign accept[gi]    = req_valid[gi] & req_ready[gi];
`ifdef REGARB_ZERO_DROP_EN
      // The handshake still completes so the core does not stall on r0 writes.
      assign fill[gi] = accept[gi] & (req_addr[gi*ADDR_W +: ADDR_W] != '0);
`else
      assign fill[gi] = accept[gi];
`endif
    end
  endgenerate

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < CORES; i++) begin
      pend_addr_d[i] = pend_addr_q[i];
      pend_data_d[i] = pend_data_q[i];
      if (gnt[i]) begin
        pend_d[i] = 1'b0;
      end
      if (fill[i]) begin
        pend_d[i]      = 1'b1;
        pend_addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
        pend_data_d[i] = req_data[i*DATA_W +: DATA_W];
      end
    end

    wr_en_d    = any_gnt;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (any_gnt) begin
      wr_addr_d  = pend_addr_q[gnt_idx];
      wr_data_d  = pend_data_q[gnt_idx];
      grant_id_d = gnt_idx;
      rr_ptr_d   = (gnt_idx == ID_W'(CORES-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      rr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
      for (int i = 0; i < CORES; i++) begin
        pend_addr_q[i] <= '0;
        pend_data_q[i] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
      for (int i = 0; i < CORES; i++) begin
        pend_addr_q[i] <= pend_addr_d[i];
        pend_data_q[i] <= pend_data_d[i];
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_id_q;
  assign busy     = |pend_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a per-core pending-slot model.
module tb_regfile_write_arbiter;
  localparam int C  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 2;
`ifdef REGARB_ZERO_DROP_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic [C-1:0]    req_valid;
  logic [C-1:0]    req_ready;
  logic [C*AW-1:0] req_addr;
  logic [C*DW-1:0] req_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [IW-1:0]   grant_id;
  logic            busy;

  regfile_write_arbiter #(.CORES(C), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit started  = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Behavioural model: one slot per core, a rotating start index, and the last write.
  bit          m_pend [C];
  logic [31:0] m_addr [C];
  logic [31:0] m_data [C];
  int          m_rr = 0;
  bit          e_wr_en = 0;
  logic [31:0] e_addr = 0;
  logic [31:0] e_data = 0;
  int          e_gid = 0;

  typedef struct { int cyc; int gid; int addr; logic [31:0] data; } wr_t;
  wr_t log_q[$];
  logic [31:0] dut_rf [32];

  function automatic int m_winner();
    for (int k = 0; k < C; k++) begin
      if (m_pend[(m_rr + k) % C]) return (m_rr + k) % C;
    end
    return -1;
  endfunction

  function automatic void model_update();
    bit rdy [C];
    int w;
    if (reset) begin
      for (int i = 0; i < C; i++) m_pend[i] = 1'b0;
      m_rr = 0; e_wr_en = 0; e_addr = 0; e_data = 0; e_gid = 0;
      return;
    end
    w = m_winner();
    for (int i = 0; i < C; i++) rdy[i] = !m_pend[i] || (i == w);
    if (w >= 0) begin
      e_wr_en = 1; e_addr = m_addr[w]; e_data = m_data[w]; e_gid = w;
      m_pend[w] = 1'b0;
      m_rr = (w + 1) % C;
    end else begin
      e_wr_en = 0;
    end
    for (int i = 0; i < C; i++) begin
      if (req_valid[i] && rdy[i] && !(ZD && req_addr[i*AW +: AW] == 0)) begin
        m_pend[i] = 1'b1;
        m_addr[i] = 32'(req_addr[i*AW +: AW]);
        m_data[i] = req_data[i*DW +: DW];
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        int w;
        logic [C-1:0] er;
        bit eb;
        w = m_winner();
        eb = 0;
        for (int i = 0; i < C; i++) begin
          er[i] = !m_pend[i] || (i == w);
          eb = eb | m_pend[i];
        end
        check("req_ready", 64'(req_ready), 64'(er));
        check("wr_en", 64'(wr_en), 64'(e_wr_en));
        check("wr_addr", 64'(wr_addr), 64'(e_addr[AW-1:0]));
        check("wr_data", 64'(wr_data), 64'(e_data));
        check("grant_id", 64'(grant_id), 64'(e_gid));
        check("busy", 64'(busy), 64'(eb));
        if (wr_en === 1'b1) begin
          log_q.push_back('{cyc, int'(grant_id), int'(wr_addr), wr_data});
          dut_rf[wr_addr] = wr_data;
        end
      end
    end
  end

  task automatic set_req(int core, int addr, logic [31:0] data);
    req_valid[core] = 1'b1;
    req_addr[core*AW +: AW] = AW'(addr);
    req_data[core*DW +: DW] = data;
  endtask

  initial begin
    int c0;
    int sa [3];
    int sd [3];
    int fg [3];
    for (int i = 0; i < C; i++) begin m_pend[i] = 0; m_addr[i] = 0; m_data[i] = 0; end
    for (int i = 0; i < 32; i++) dut_rf[i] = 0;
    sa = '{9, 10, 11};
    sd = '{1, 2, 2};
    fg = '{1, 3, 0};

    // Reset held two cycles with every core requesting.
    reset = 1'b1; req_valid = '1;
    for (int i = 0; i < C; i++) set_req(i, i + 3, $urandom);
    tick();
    started = 1'b1;
    tick();
    @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_grant_id", 64'(grant_id), 0);
    check("rst_wr_addr", 64'(wr_addr), 0);
    check("rst_wr_data", 64'(wr_data), 0);
    reset = 1'b0; req_valid = '0;
    #1;
    check("rst_ready", 64'(req_ready), 64'hF);

    // Single uncontended core streaming three writes.
    log_q.delete();
    req_valid = '0; set_req(2, 9, 1);
    tick(); c0 = cyc;
    check("single_ready2", 64'(req_ready[2]), 1);
    req_valid = '0; set_req(2, 10, 2);
    tick();
    check("single_ready2", 64'(req_ready[2]), 1);
    req_valid = '0; set_req(2, 11, 2);
    tick();
    check("single_ready2", 64'(req_ready[2]), 1);
    req_valid = '0;
    repeat (4) tick();
    check("single_count", 64'(log_q.size()), 3);
    for (int k = 0; k < 3 && k < log_q.size(); k++) begin
      check("single_cycle", 64'(log_q[k].cyc), 64'(c0 + 1 + k));
      check("single_gid", 64'(log_q[k].gid), 2);
      check("single_addr", 64'(log_q[k].addr), 64'(sa[k]));
      check("single_data", 64'(log_q[k].data), 64'(sd[k]));
    end

    // All four cores at once, straight after a reset.
    reset = 1'b1; tick(); reset = 1'b0;
    log_q.delete();
    for (int i = 9; i <= 12; i++) dut_rf[i] = 0;
    set_req(0, 9, 1); set_req(1, 10, 2); set_req(2, 11, 2); set_req(3, 12, 6);
    tick(); c0 = cyc;
    req_valid = '0;
    @(negedge clk);
    check("contend_ready", 64'(req_ready), 64'b0001);
    check("contend_busy", 64'(busy), 1);
    repeat (5) tick();
    check("contend_count", 64'(log_q.size()), 4);
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      check("contend_gid", 64'(log_q[k].gid), 64'(k));
      check("contend_cycle", 64'(log_q[k].cyc), 64'(c0 + 1 + k));
    end
    check("rf9", 64'(dut_rf[9]), 1);
    check("rf10", 64'(dut_rf[10]), 2);
    check("rf11", 64'(dut_rf[11]), 2);
    check("rf12", 64'(dut_rf[12]), 6);

    // Fairness: after core 1 wins, core 3 goes ahead of core 0.
    log_q.delete();
    req_valid = '0; set_req(1, 5, 7);
    tick();
    req_valid = '0; set_req(0, 6, 8); set_req(3, 7, 9);
    tick();
    req_valid = '0;
    repeat (4) tick();
    check("fair_count", 64'(log_q.size()), 3);
    for (int k = 0; k < 3 && k < log_q.size(); k++)
      check("fair_gid", 64'(log_q[k].gid), 64'(fg[k]));

    // Write to register 0.
    log_q.delete();
    req_valid = '0; set_req(0, 0, 32'hDEADBEEF);
    tick();
    req_valid = '0;
    repeat (3) tick();
`ifdef REGARB_ZERO_DROP_EN
    check("zero_count", 64'(log_q.size()), 0);
`else
    check("zero_count", 64'(log_q.size()), 1);
    if (log_q.size() > 0) begin
      check("zero_addr", 64'(log_q[0].addr), 0);
      check("zero_data", 64'(log_q[0].data), 64'hDEADBEEF);
    end
`endif

    // Reset while three entries are pending.
    log_q.delete();
    req_valid = '0; set_req(0, 1, 11); set_req(1, 2, 22); set_req(2, 3, 33);
    tick();
    req_valid = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_wr_en", 64'(wr_en), 0);
    repeat (5) tick();
    check("midrst_count", 64'(log_q.size()), 0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(63) == 0);
      req_valid = C'($urandom);
      for (int i = 0; i < C; i++) begin
        req_addr[i*AW +: AW] = ($urandom_range(7) == 0) ? '0 : AW'($urandom);
        req_data[i*DW +: DW] = $urandom;
      end
      tick();
    end
    reset = 1'b0; req_valid = '0;
    repeat (6) tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
